fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer for the simple-cycle core. It owns the program counter and drives the instruction memory through a req/ready handshake. It presents each fetched instruction to the decode/execute stage and holds it while that stage stalls. It then applies the Branch/Zero redirect or an asynchronous-to-pipeline flush before issuing the next fetch. It replaces free-running PC update logic, so the core tolerates multi-cycle memory latency.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset (bits [1:0] must be 0)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Branch  in  1  presented instruction is a conditional branch
- Zero  in  1  ALU zero flag for the presented instruction
- branchtarget  in  32  branch destination; bits [1:0] ignored (forced 0)
- stall  in  1  downstream not accepting the presented instruction this cycle
- flush  in  1  redirect request (jump/exception), accepted any cycle
- flush_pc  in  32  flush destination; bits [1:0] ignored
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, stable while imem_req high
- imem_ready  in  1  memory response; imem_rdata valid in same cycle
- imem_rdata  in  32  fetched word
- instr_valid  out  1  instruction/instr_pc valid
- instruction  out  32  presented instruction
- instr_pc  out  32  address of presented instruction
- PC  out  32  address of next fetch
- retired  out  32  count of instructions consumed

## Operation
- States: IDLE, FETCH, EXEC, DRAIN.
- IDLE: imem_req=0, instr_valid=0. Transitions unconditionally to FETCH.
- FETCH: imem_req=1, imem_addr=addr register. addr is loaded from PC on entry to FETCH.
  - ready=1, no flush: instruction<=imem_rdata, instr_pc<=addr, PC<=addr+4, go to EXEC.
  - ready=1 with flush: discard the data, PC<=flush_pc, re-enter FETCH.
  - ready=0 with flush: PC<=flush_pc, go to DRAIN.
- EXEC: instr_valid=1, imem_req=0. Priority order:
  1. flush: PC<=flush_pc, go to FETCH; retired is not incremented.
  2. stall: hold all state.
  3. otherwise (consume): retired<=retired+1. If Branch&Zero, PC<=branchtarget. Go to FETCH.
- DRAIN: imem_req=1 with imem_addr held at the abandoned address.
  - Wait for ready; drop the data; go to FETCH.
  - A further flush while in DRAIN overwrites PC; the last one wins.
- Branch and Zero are sampled only on the EXEC consume cycle and ignored in other states.
- Arithmetic: PC+4 wraps modulo 2^32. retired wraps modulo 2^32.
- instruction and instr_pc hold their last values outside EXEC; only instr_valid qualifies them.

## Timing
- Reset (reset sampled high at an edge):
  - State goes to IDLE, PC=RESET_PC, addr=RESET_PC.
  - instruction=0, instr_pc=0, retired=0, instr_valid=0, imem_req=0.
- Reset mid-fetch abandons the request. imem_req drops the cycle after the reset edge, and the memory must not require completion.
- imem_req first rises on the second cycle after reset deasserts (one cycle in IDLE).
- Fetch latency: a zero-wait memory (ready in the first req cycle) gives instr_valid on the next cycle. Each extra wait cycle adds one.
- Peak throughput: one instruction per 2 cycles (FETCH + EXEC) with zero-wait memory and no stall.
- Once imem_req=1, imem_req and imem_addr are constant until the edge where imem_ready=1.
- instr_valid rises exactly one cycle after the accepting ready edge. It falls the cycle after consume or flush.
- imem_req and instr_valid are never high in the same cycle.
- retired increments on the consume edge and is visible the following cycle.

## Test plan
- Sequential fetch: reset with RESET_PC=0, zero-wait memory, stall=0 for 20 cycles -> imem_addr sequence is 0,4,8,...; instr_pc matches; retired=N after N instr_valid pulses.
- Wait states: memory asserts ready 3 cycles after req -> imem_addr stable throughout; instr_valid follows one cycle after ready; no duplicate or skipped PC.
- Taken branch: instruction at 0x10 consumed with Branch=1, Zero=1, branchtarget=0x00001103 -> next imem_addr=0x00001100. The same with Zero=0 -> next imem_addr=0x14.
- Stall: stall=1 for 5 cycles during EXEC -> instruction/instr_pc held, imem_req=0, retired unchanged. Release -> single increment.
- Flush mid-fetch: flush_pc=0x200 during FETCH with ready delayed 2 cycles -> DRAIN holds the old address until ready; dropped data never appears (instr_valid stays 0); next imem_addr=0x200. Flush arriving in the same cycle as ready -> next imem_addr=0x200 with no instr_valid.
- Reset mid-operation: assert reset during FETCH and during a stalled EXEC -> the next cycle shows imem_req=0, instr_valid=0, PC=RESET_PC, retired=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ready handshake,
// presents fetched instructions to decode/execute and applies branch/flush redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] branchtarget,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] PC,
  output logic [31:0] retired
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic [XLEN-1:0]   retired_q, retired_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   flush_addr;
  logic [XLEN-1:0]   branch_addr;

  assign flush_addr  = flush_pc & ALIGN_MASK;
  assign branch_addr = branchtarget & ALIGN_MASK;

  // Next-state and next-output logic; addr is reloaded on every entry to FETCH.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        addr_d  = pc_q;
      end
      FETCH: begin
        if (imem_ready) begin
          if (flush) begin
            pc_d   = flush_addr;
            addr_d = flush_addr;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = addr_q;
            pc_d    = addr_q + INSTR_BYTES;
            state_d = EXEC;
          end
        end else if (flush) begin
          pc_d    = flush_addr;
          state_d = DRAIN;
        end
      end
      EXEC: begin
        if (flush) begin
          pc_d    = flush_addr;
          addr_d  = flush_addr;
          state_d = FETCH;
        end else if (!stall) begin
          retired_d = retired_q + XLEN'(1);
          state_d   = FETCH;
          if (Branch && Zero) begin
            pc_d   = branch_addr;
            addr_d = branch_addr;
          end else begin
            addr_d = pc_q;
          end
        end
      end
      DRAIN: begin
        // The abandoned request must complete before the redirect is issued.
        if (flush) pc_d = flush_addr;
        if (imem_ready) begin
          state_d = FETCH;
          addr_d  = flush ? flush_addr : pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == FETCH) || (state_d == DRAIN);
    valid_d = (state_d == EXEC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      instr_q   <= '0;
      ipc_q     <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;
  assign PC          = pc_q;
  assign retired     = retired_q;

endmodule
